// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the neural-network datapath blocks.
//   ag_state_t   - address generator / control unit handshake states
//   addr_width() - address width for a given number of locations (min 1 bit)
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ag_state_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MODULUS up-counter.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, forces count to 0
//   clear - synchronous clear, has priority over en
//   en    - advance by one; wraps from MODULUS-1 to 0
//   count - current count
//   wrap  - high in the cycle an enabled advance wraps to 0
module wrap_counter
    import nn_pkg::*;
#(
    parameter int unsigned MODULUS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             en,
    output logic [addr_width(MODULUS)-1:0]   count,
    output logic                             wrap
);

    localparam int unsigned CW = addr_width(MODULUS);
    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/address_generator.sv
// address_generator: walks the weight and input-vector addresses for one
// layer, neuron by neuron, one address per AG_read from the control unit.
//   clk        - rising-edge clock
//   reset      - asynchronous active-high reset
//   AG_rst     - synchronous restart to IDLE (overrides AG_read)
//   AG_read    - start the sweep (IDLE) / consume the current address (RUN)
//   w_addr     - weight address, neuron_idx*N_INPUTS + x_addr
//   x_addr     - input-vector address
//   neuron_idx - current neuron
//   addr_valid - addresses are valid (RUN)
//   last_input - current address is the last input of the neuron
//   done       - all N_INPUTS*N_NEURONS addresses consumed
module address_generator
    import nn_pkg::*;
#(
    parameter int unsigned N_INPUTS  = 4,
    parameter int unsigned N_NEURONS = 3
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        AG_rst,
    input  logic                                        AG_read,
    output logic [addr_width(N_INPUTS*N_NEURONS)-1:0]   w_addr,
    output logic [addr_width(N_INPUTS)-1:0]             x_addr,
    output logic [addr_width(N_NEURONS)-1:0]            neuron_idx,
    output logic                                        addr_valid,
    output logic                                        last_input,
    output logic                                        done
);

    localparam int unsigned W_W = addr_width(N_INPUTS * N_NEURONS);
    localparam int unsigned X_W = addr_width(N_INPUTS);
    localparam int unsigned N_W = addr_width(N_NEURONS);

    ag_state_t state, state_next;
    logic      consume;
    logic      final_read;
    logic      advance;
    logic      x_last;
    logic      n_last;
    logic      x_wrap;
    // The final read stops the sweep before the neuron counter could wrap.
    logic      neuron_wrap_unused;

    assign x_last  = (x_addr == X_W'(N_INPUTS - 1));
    assign n_last  = (neuron_idx == N_W'(N_NEURONS - 1));
    assign advance = consume && !final_read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        consume    = 1'b0;
        final_read = 1'b0;
        if (AG_rst) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (AG_read) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (AG_read) begin
                        consume = 1'b1;
                        if (x_last && n_last) begin
                            final_read = 1'b1;
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    wrap_counter #(.MODULUS(N_INPUTS)) u_x_counter (
        .clk   (clk),
        .reset (reset),
        .clear (AG_rst),
        .en    (advance),
        .count (x_addr),
        .wrap  (x_wrap)
    );

    wrap_counter #(.MODULUS(N_NEURONS)) u_neuron_counter (
        .clk   (clk),
        .reset (reset),
        .clear (AG_rst),
        .en    (x_wrap),
        .count (neuron_idx),
        .wrap  (neuron_wrap_unused)
    );

    // w_addr steps alongside x_addr, so it tracks neuron_idx*N_INPUTS+x_addr
    // without a multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr     <= '0;
            addr_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (AG_rst) begin
                w_addr <= '0;
            end else if (advance) begin
                w_addr <= w_addr + W_W'(1);
            end
            addr_valid <= (state_next == ST_RUN);
            done       <= (state_next == ST_DONE);
        end
    end

    assign last_input = addr_valid && x_last;

endmodule

// File: tb/tb_address_generator.sv
// tb_address_generator: randomized scoreboard bench for address_generator
// with N_INPUTS=4, N_NEURONS=3.
module tb_address_generator;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int TOTAL = NI * NN;

    logic       clk = 1'b0;
    logic       reset;
    logic       AG_rst;
    logic       AG_read;
    logic [3:0] w_addr;
    logic [1:0] x_addr;
    logic [1:0] neuron_idx;
    logic       addr_valid;
    logic       last_input;
    logic       done;

    always #5 clk = ~clk;

    address_generator #(
        .N_INPUTS  (NI),
        .N_NEURONS (NN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .AG_rst     (AG_rst),
        .AG_read    (AG_read),
        .w_addr     (w_addr),
        .x_addr     (x_addr),
        .neuron_idx (neuron_idx),
        .addr_valid (addr_valid),
        .last_input (last_input),
        .done       (done)
    );

    typedef struct {
        int w;
        int x;
        int n;
    } addr_t;

    addr_t exp_q[$];
    int    errors   = 0;
    int    checks   = 0;
    int    consumed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: the k-th consumed address of a sweep is weight k,
    // input k mod N_INPUTS, neuron k div N_INPUTS.
    task automatic push_sweep();
        for (int k = 0; k < TOTAL; k++) begin
            exp_q.push_back('{k, k % NI, k / NI});
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, addr_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_w"}, w_addr, 0);
        check({tag, "_x"}, x_addr, 0);
        check({tag, "_n"}, neuron_idx, 0);
        check({tag, "_last"}, last_input, 0);
    endtask

    task automatic check_done_state(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_valid"}, addr_valid, 0);
        check({tag, "_w"}, w_addr, TOTAL - 1);
        check({tag, "_x"}, x_addr, NI - 1);
        check({tag, "_n"}, neuron_idx, NN - 1);
    endtask

    // mode 0: AG_read held, 1: toggled 1,0,1,0, 2: random
    task automatic run_sweep(input int mode, input string tag);
        int start_consumed;
        bit got_done;
        start_consumed = consumed;
        got_done = 1'b0;
        push_sweep();
        for (int c = 0; c < 300; c++) begin
            case (mode)
                0:       AG_read = 1'b1;
                1:       AG_read = (c % 2 == 0);
                default: AG_read = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
            if (mode == 0 && c == 0) check({tag, "_latency"}, addr_valid, 1);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        AG_read = 1'b0;
        check({tag, "_done_reached"}, got_done, 1);
        check({tag, "_consumptions"}, consumed - start_consumed, TOTAL);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check_done_state(tag);
    endtask

    task automatic run_until_w(input int target, input string tag);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (addr_valid && w_addr == 4'(target)) begin
                found = 1'b1;
                break;
            end
            AG_read = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check({tag, "_reached_target"}, found, 1);
    endtask

    task automatic restart(input string tag);
        AG_read = 1'b0;
        AG_rst  = 1'b1;
        @(posedge clk); #1;
        AG_rst = 1'b0;
        check_idle(tag);
    endtask

    // Monitor: scoreboard on every consumed address, invariants every cycle.
    initial begin
        addr_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("w_invariant", w_addr, neuron_idx * NI + x_addr);
                check("last_input_invariant", last_input, (addr_valid && x_addr == NI - 1));
                if (addr_valid && AG_read && !AG_rst) begin
                    consumed++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_consume: got w=%0d expected no consumption", w_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_w", w_addr, e.w);
                        check("sb_x", x_addr, e.x);
                        check("sb_n", neuron_idx, e.n);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        AG_rst  = 1'b0;
        AG_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("after_release");

        // AG_read held high for a full sweep
        run_sweep(0, "held");

        // DONE ignores AG_read
        AG_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_done_state("done_hold");
        end
        restart("rst_from_done");

        // toggled AG_read
        run_sweep(1, "toggle");
        restart("rst_after_toggle");

        // AG_rst and AG_read together at w_addr=6
        push_sweep();
        run_until_w(6, "agrst");
        AG_rst  = 1'b1;
        AG_read = 1'b1;
        @(posedge clk); #1;
        AG_rst  = 1'b0;
        AG_read = 1'b0;
        check_idle("agrst_over_read");
        exp_q.delete();
        @(posedge clk); #1;
        check_idle("agrst_stays_idle");
        run_sweep(2, "after_agrst");
        restart("rst_after_random");

        // async reset between edges at w_addr=5
        push_sweep();
        run_until_w(5, "async");
        AG_read = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_immediate");
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check_idle("async_released");
        run_sweep(2, "after_async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/address_generator.md
ADDRESS_GENERATOR -- requirements
Module: address_generator

Interface
REQ-001 Parameter N_INPUTS, 4, inputs per neuron (>=2).
REQ-002 Parameter N_NEURONS, 3, neurons in layer (>=2).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port AG_rst  input  1  synchronous restart request from control unit.
REQ-006 Port AG_read  input  1  advance request from control unit; consumes current address when addr_valid=1.
REQ-007 Port w_addr  output  clog2(N_INPUTS*N_NEURONS)  weight memory address.
REQ-008 Port x_addr  output  clog2(N_INPUTS)  input-vector address.
REQ-009 Port neuron_idx  output  clog2(N_NEURONS)  current neuron index.
REQ-010 Port addr_valid  output  1  addresses on w_addr/x_addr/neuron_idx are valid.
REQ-011 Port last_input  output  1  high while addr_valid=1 and x_addr=N_INPUTS-1.
REQ-012 Port done  output  1  high when all N_INPUTS*N_NEURONS addresses have been consumed.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding registered.
REQ-014 IDLE: addr_valid=0, done=0, counters 0; AG_read=1 -> RUN next cycle with w_addr=0, x_addr=0, neuron_idx=0, addr_valid=1 (latency 1 cycle).
REQ-015 RUN, AG_read=1: address consumed; next cycle x_addr+1, w_addr+1, neuron_idx unchanged, except as in REQ-016/017.
REQ-016 RUN, AG_read=1, x_addr=N_INPUTS-1, neuron_idx<N_NEURONS-1: x_addr wraps to 0, neuron_idx+1, w_addr+1.
REQ-017 RUN, AG_read=1, x_addr=N_INPUTS-1, neuron_idx=N_NEURONS-1: next state DONE; addr_valid=0, done=1.
REQ-018 RUN, AG_read=0: all outputs hold; addr_valid stays 1 (no timeout).
REQ-019 DONE: done=1, addr_valid=0, address outputs hold last values; AG_read ignored.
REQ-020 AG_rst=1 in any state SHALL force IDLE, counters 0, done=0, addr_valid=0 next cycle; AG_rst overrides AG_read in the same cycle.
REQ-021 w_addr SHALL equal neuron_idx*N_INPUTS+x_addr at all times, maintained as an incrementing counter (no multiplier).
REQ-022 last_input SHALL be combinational from registered state; all other outputs registered.
REQ-023 Exactly N_INPUTS*N_NEURONS AG_read-consumed cycles SHALL occur between leaving IDLE and entering DONE.

Reset
REQ-024 reset=1 SHALL asynchronously force IDLE, w_addr=0, x_addr=0, neuron_idx=0, addr_valid=0, done=0, independent of clk.
REQ-025 Release of reset SHALL leave block in IDLE; first transition requires AG_read=1 at a subsequent edge.
REQ-026 reset asserted mid-RUN SHALL abort the sweep; no partial state retained.

Structure
REQ-027 FSM state typedef and state encoding constants SHALL reside in shared package nn_pkg, reused by the control unit.
REQ-028 Address widths SHALL be derived from parameters via $clog2 in nn_pkg helper functions.
REQ-029 One sub-module, wrap_counter (parameterised modulus, enable, sync clear, wrap pulse), SHALL implement x_addr and neuron_idx counters.

Verification (N_INPUTS=4, N_NEURONS=3)
REQ-030 Reset then AG_read held 1 -> addr_valid rises 1 cycle later; w_addr sequence 0..11, x_addr 0,1,2,3 repeating, neuron_idx 0,0,0,0,1,...,2; done=1 after 12th consumed cycle.
REQ-031 AG_read toggled 1,0,1,0 in RUN -> addresses advance only on AG_read=1 cycles; still exactly 12 consumptions before done.
REQ-032 AG_rst and AG_read both 1 at w_addr=6 -> next cycle IDLE, all outputs 0; AG_read then restarts at w_addr=0.
REQ-033 Async reset pulsed between clock edges at w_addr=5 -> outputs 0 immediately, before next edge.
REQ-034 In DONE, AG_read=1 for 5 cycles -> done stays 1, addr_valid 0, w_addr holds 11; AG_rst -> IDLE.
REQ-035 Throughout all scenarios, assertion w_addr==neuron_idx*4+x_addr and last_input==(addr_valid && x_addr==3) holds every cycle.
